// File: rtl/udp_rx.sv
// udp_rx: UDP receive stage that parses the header, filters by port and length, and streams the payload to the application
module udp_rx #(
  parameter bit PORT_FILTER_EN = 1'b1,
  parameter int MIN_UDP_LEN    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] local_udp_port,
  input  logic        udp_rx_req,
  input  logic [7:0]  udp_rx_data,
  input  logic [15:0] upper_layer_data_length,
  input  logic        ip_addr_check_error,
  input  logic        ip_checksum_error,
  output logic [7:0]  udp_rec_data,
  output logic        udp_rec_data_valid,
  output logic [15:0] udp_rec_source_port,
  output logic [15:0] udp_rec_dest_port,
  output logic [15:0] udp_rec_data_length,
  output logic        udp_rx_end,
  output logic        udp_port_error,
  output logic        udp_length_error,
  output logic        udp_rx_abort
);
  typedef enum logic [3:0] {
    IDLE       = 4'b0001,
    REC_HEADER = 4'b0010,
    REC_DATA   = 4'b0100,
    REC_END    = 4'b1000
  } state_t;
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d, ip_len_q, ip_len_d, src_q, src_d, dst_q, dst_d;
  logic [15:0] len_q, len_d, dlen_q, dlen_d;
  logic [7:0] data_q, data_d;
  logic valid_q, valid_d, end_q, end_d, perr_q, perr_d, lerr_q, lerr_d, abort_q, abort_d;
  logic hdr, dat, abort, last, k7, len_bad, port_bad, stop;
  always_comb begin
    hdr      = state_q == REC_HEADER;
    dat      = state_q == REC_DATA;
    abort    = (hdr || dat) && (ip_checksum_error || ip_addr_check_error);
    last     = dat && cnt_q == len_q - 16'd1;
    k7       = hdr && cnt_q == 16'd7;
    len_bad  = len_q < 16'(MIN_UDP_LEN) || len_q > ip_len_q;
    port_bad = PORT_FILTER_EN && dst_q != local_udp_port;
    stop     = abort || last || (k7 && (len_bad || port_bad || len_q == 16'd8));
    state_d  = state_q == IDLE ? (udp_rx_req ? REC_HEADER : IDLE) :
               stop ? REC_END : k7 ? REC_DATA : (hdr || dat) ? state_q : IDLE;
    cnt_d    = (hdr || dat) ? cnt_q + 16'd1 : 16'd0;
    ip_len_d = (state_q == IDLE && udp_rx_req) ? upper_layer_data_length : ip_len_q;
    src_d    = hdr && cnt_q == 16'd0 ? {udp_rx_data, src_q[7:0]} :
               hdr && cnt_q == 16'd1 ? {src_q[15:8], udp_rx_data} : src_q;
    dst_d    = hdr && cnt_q == 16'd2 ? {udp_rx_data, dst_q[7:0]} :
               hdr && cnt_q == 16'd3 ? {dst_q[15:8], udp_rx_data} : dst_q;
    len_d    = hdr && cnt_q == 16'd4 ? {udp_rx_data, len_q[7:0]} :
               hdr && cnt_q == 16'd5 ? {len_q[15:8], udp_rx_data} : len_q;
    dlen_d   = k7 ? (len_bad ? 16'd0 : len_q - 16'd8) : dlen_q;
    data_d   = dat ? udp_rx_data : data_q;
    valid_d  = dat && (!abort || last);
    end_d    = !abort && (last || (k7 && !len_bad && !port_bad && len_q == 16'd8));
    lerr_d   = k7 && !abort && len_bad;
    perr_d   = k7 && !abort && !len_bad && port_bad;
    abort_d  = abort;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ip_len_q <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      dlen_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      end_q    <= 1'b0;
      perr_q   <= 1'b0;
      lerr_q   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ip_len_q <= ip_len_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      dlen_q   <= dlen_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      end_q    <= end_d;
      perr_q   <= perr_d;
      lerr_q   <= lerr_d;
      abort_q  <= abort_d;
    end
  end
  assign udp_rec_data        = data_q;
  assign udp_rec_data_valid  = valid_q;
  assign udp_rec_source_port = src_q;
  assign udp_rec_dest_port   = dst_q;
  assign udp_rec_data_length = dlen_q;
  assign udp_rx_end          = end_q;
  assign udp_port_error      = perr_q;
  assign udp_length_error    = lerr_q;
  assign udp_rx_abort        = abort_q;
endmodule

// File: tb/tb_udp_rx.sv
// tb_udp_rx: scoreboard bench for udp_rx with filtering and non-filtering instances
module tb_udp_rx;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0, addr_err = 1'b0, ck_err = 1'b0, sel = 1'b0;
  logic [15:0] local_port = 16'h1F90, ulen = '0;
  logic [7:0] din = '0;
  logic [7:0] a_data, b_data;
  logic [15:0] a_src, a_dst, a_dlen, b_src, b_dst, b_dlen;
  logic a_valid, a_end, a_perr, a_lerr, a_abort, b_valid, b_end, b_perr, b_lerr, b_abort;
  int cyc = 0, total = 0, bad = 0;
  logic [63:0] q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  udp_rx dut (
    .clk(clk), .rst(rst), .local_udp_port(local_port), .udp_rx_req(req), .udp_rx_data(din),
    .upper_layer_data_length(ulen), .ip_addr_check_error(addr_err), .ip_checksum_error(ck_err),
    .udp_rec_data(a_data), .udp_rec_data_valid(a_valid), .udp_rec_source_port(a_src),
    .udp_rec_dest_port(a_dst), .udp_rec_data_length(a_dlen), .udp_rx_end(a_end),
    .udp_port_error(a_perr), .udp_length_error(a_lerr), .udp_rx_abort(a_abort)
  );
  udp_rx #(.PORT_FILTER_EN(1'b0)) dut_nf (
    .clk(clk), .rst(rst), .local_udp_port(local_port), .udp_rx_req(req), .udp_rx_data(din),
    .upper_layer_data_length(ulen), .ip_addr_check_error(addr_err), .ip_checksum_error(ck_err),
    .udp_rec_data(b_data), .udp_rec_data_valid(b_valid), .udp_rec_source_port(b_src),
    .udp_rec_dest_port(b_dst), .udp_rec_data_length(b_dlen), .udp_rx_end(b_end),
    .udp_port_error(b_perr), .udp_length_error(b_lerr), .udp_rx_abort(b_abort)
  );
  wire [7:0] m_data = sel ? b_data : a_data;
  wire m_valid = sel ? b_valid : a_valid;
  wire [15:0] m_src = sel ? b_src : a_src;
  wire [15:0] m_dst = sel ? b_dst : a_dst;
  wire [15:0] m_dlen = sel ? b_dlen : a_dlen;
  wire m_end = sel ? b_end : a_end;
  wire m_perr = sel ? b_perr : a_perr;
  wire m_lerr = sel ? b_lerr : a_lerr;
  wire m_abort = sel ? b_abort : a_abort;
  wire [60:0] m_all = {m_data, m_valid, m_src, m_dst, m_dlen, m_end, m_perr, m_lerr, m_abort};
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask
  task automatic expect_ev(input int kind, input logic [7:0] d);
    q.push_back({32'(cyc + 1), 24'(kind), d});
  endtask
  task automatic pop_ev(input int kind, input logic [7:0] d);
    logic [63:0] act;
    act = {32'(cyc), 24'(kind), d};
    if (q.size() == 0) check("unexpected", act, 64'hFFFF_FFFF_FFFF_FFFF);
    else check("event", act, q.pop_front());
  endtask
  always @(negedge clk) begin
    if (m_valid) pop_ev(0, m_data);
    if (m_end) pop_ev(1, 8'd0);
    if (m_perr) pop_ev(2, 8'd0);
    if (m_lerr) pop_ev(3, 8'd0);
    if (m_abort) pop_ev(4, 8'd0);
  end
  task automatic send(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                      input logic [15:0] ip_len, input int npay, input int abort_at = -1,
                      input int req2_at = -1, input int rst_at = -1);
    logic [63:0] hdr;
    bit done, decided, was_rst, filt;
    hdr = {src, dst, len, 16'hBEEF};
    done = 0;
    decided = 0;
    was_rst = 0;
    filt = !sel;
    @(negedge clk);
    req = 1'b1;
    ulen = ip_len;
    for (int k = 0; k < 8 + npay; k++) begin
      @(negedge clk);
      if (rst_at >= 0 && k == rst_at + 1) begin
        check("rst_out", 64'(m_all), 64'd0);
        rst = 1'b0;
      end
      req = k == req2_at;
      ulen = req ? 16'hFFFF : ip_len;
      din = k < 8 ? hdr[63 - 8 * k -: 8] : 8'(k - 8);
      ck_err = k == abort_at;
      if (k == rst_at) begin
        rst = 1'b1;
        was_rst = 1;
        done = 1;
      end
      if (!done) begin
        if (k == abort_at) begin
          if (k >= 8 && k == int'(len) - 1) expect_ev(0, din);
          expect_ev(4, 8'd0);
          done = 1;
        end else if (k == 7) begin
          decided = 1;
          done = 1;
          if (len < 16'd8 || len > ip_len) expect_ev(3, 8'd0);
          else if (filt && dst != local_port) expect_ev(2, 8'd0);
          else if (len == 16'd8) expect_ev(1, 8'd0);
          else done = 0;
        end else if (k >= 8) begin
          expect_ev(0, din);
          if (k == int'(len) - 1) begin
            expect_ev(1, 8'd0);
            done = 1;
          end
        end
      end
    end
    @(negedge clk);
    req = 1'b0;
    din = '0;
    ck_err = 1'b0;
    rst = 1'b0;
    #1;
    check("pending", 64'(q.size()), 64'd0);
    q.delete();
    if (decided && !was_rst) begin
      check("src", 64'(m_src), 64'(src));
      check("dst", 64'(m_dst), 64'(dst));
      check("dlen", 64'(m_dlen), (len < 16'd8 || len > ip_len) ? 64'd0 : 64'(len - 16'd8));
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("reset", 64'(m_all), 64'd0);
    rst = 1'b0;
    send(16'h1F90, 16'h1F90, 16'h0012, 16'd18, 10);
    send(16'h1234, 16'h1F90, 16'h000A, 16'd26, 18);
    send(16'h0400, 16'h1F91, 16'h0012, 16'd18, 10);
    sel = 1'b1;
    send(16'h0400, 16'h1F91, 16'h0012, 16'd18, 10);
    sel = 1'b0;
    send(16'h0001, 16'h1F90, 16'h0006, 16'd18, 10);
    send(16'h0002, 16'h1F90, 16'h0020, 16'h0018, 16);
    send(16'h0003, 16'h1F90, 16'h0008, 16'd8, 0);
    send(16'h0004, 16'h1F90, 16'd28, 16'd28, 20, 11);
    send(16'h0005, 16'h1F90, 16'd28, 16'd28, 20, 27);
    send(16'h0006, 16'h1F90, 16'd28, 16'd28, 20, 3);
    send(16'h0007, 16'h1F90, 16'h0012, 16'd18, 10, -1, 10);
    send(16'h0008, 16'h1F90, 16'h0012, 16'd18, 10, -1, -1, 12);
    send(16'h0009, 16'h1F90, 16'h0012, 16'd18, 10);
    send(16'h000A, 16'h1F90, 16'h000C, 16'd12, 4);
    for (int i = 0; i < 6; i++) begin
      logic [15:0] l;
      int pad;
      l = 16'(8 + $urandom_range(0, 30));
      pad = $urandom_range(0, 5);
      send(16'($urandom), $urandom_range(0, 3) == 0 ? 16'h1F91 : 16'h1F90, l, l + 16'(pad), int'(l) - 8 + pad);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/udp_rx.md
Name: udp_rx

Overview:
- Transport-layer receive stage that sits directly downstream of the IP receive parser.
- Starts on the parser's one-cycle UDP request pulse and consumes the IP payload byte stream.
- Parses the 8-byte UDP header, filters on the local destination port and validates the UDP length field against the IP-derived payload length.
- Streams the UDP payload bytes to the application with a valid strobe and an end pulse, and aborts cleanly when the IP stage flags an error.

Parameters:
PORT_FILTER_EN, 1, 1 = drop datagrams whose destination port differs from local_udp_port; 0 = accept any port
MIN_UDP_LEN, 8, smallest legal UDP length field (header only)

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
local_udp_port  input  16  port this node accepts
udp_rx_req  input  1  one-cycle start pulse from the IP stage; first UDP byte arrives on udp_rx_data the following cycle
udp_rx_data  input  8  IP payload byte stream, one byte per cycle, no stalls
upper_layer_data_length  input  16  IP total length minus IP header length; sampled on the udp_rx_req cycle
ip_addr_check_error  input  1  level; high = packet not addressed to this node
ip_checksum_error  input  1  pulse; IP header checksum failed
udp_rec_data  output  8  payload byte
udp_rec_data_valid  output  1  udp_rec_data qualifier
udp_rec_source_port  output  16  source port of the current/last datagram
udp_rec_dest_port  output  16  destination port of the current/last datagram
udp_rec_data_length  output  16  payload length = UDP length field - 8
udp_rx_end  output  1  one-cycle pulse marking successful datagram completion
udp_port_error  output  1  one-cycle pulse: port mismatch
udp_length_error  output  1  one-cycle pulse: bad length field
udp_rx_abort  output  1  one-cycle pulse: IP-level error terminated reception

Behaviour:
- Reset: state = IDLE, byte counter = 0, every output = 0.
- FSM is one-hot, 4 bits: IDLE, REC_HEADER, REC_DATA, REC_END.
- IDLE:
  - On udp_rx_req: latch upper_layer_data_length into ip_len, clear the counter, go to REC_HEADER.
  - udp_rx_req in any other state is ignored.
- Byte counter: 16 bits, counts in REC_HEADER and REC_DATA, cleared in IDLE and REC_END; it never wraps (max length is 65535).
- REC_HEADER, header byte at counter k (big-endian):
  - k = 0..1: source port.
  - k = 2..3: destination port.
  - k = 4..5: UDP length field.
  - k = 6..7: checksum (consumed, not verified).
- Decision on the k = 7 cycle, priority order:
  1. Length field < MIN_UDP_LEN or > ip_len: udp_length_error pulse next cycle, go to REC_END.
  2. PORT_FILTER_EN and dest port != local_udp_port: udp_port_error pulse next cycle, go to REC_END.
  3. Length field == 8: udp_rx_end pulse next cycle, go to REC_END (empty payload, valid never asserted).
  4. Otherwise go to REC_DATA.
- udp_rec_data_length is written on the k = 7 cycle as length field - 8, and as 0 when rule 1 fires.
- Port outputs update as their bytes arrive and hold until the next datagram.
- REC_DATA:
  - Each input byte appears on udp_rec_data with valid = 1 exactly one cycle later (registered, latency 1).
  - The last payload byte is the one at counter == length field - 1.
  - udp_rx_end is asserted in the same output cycle as the last valid byte; then go to REC_END.
- Ethernet padding beyond the UDP length is never forwarded.
- REC_END lasts one cycle, then IDLE.
- Abort: ip_checksum_error high, or ip_addr_check_error high, during REC_HEADER or REC_DATA:
  - Go to REC_END.
  - udp_rx_abort pulses next cycle.
  - valid drops next cycle, so no further bytes are forwarded.
  - udp_rx_end is not asserted for that datagram.
- Simultaneous events:
  - Abort outranks the k = 7 decision.
  - Abort outranks the last-byte end in the same cycle: the last byte is still output with valid, but udp_rx_abort is asserted instead of udp_rx_end.
- Reset asserted mid-datagram forces IDLE and zeroes all outputs on the next edge; the remainder of the stream is ignored until a new udp_rx_req.
- Error and end pulses are mutually exclusive per datagram; exactly one of udp_rx_end, udp_port_error, udp_length_error or udp_rx_abort fires per accepted udp_rx_req.

Test Plan:
1. Nominal: port 8080 local, ip_len=18, header 1F90 1F90 0012 0000, payload 00..09 -> source = dest = 0x1F90, length=10, ten valid bytes 00..09 at latency 1, udp_rx_end coincident with byte 09.
2. Padding: UDP length 0x000A, ip_len=26, 16 further pad bytes -> two valid bytes, udp_rx_end once, pad bytes never valid.
3. Port filter: dest 0x1F91, local 0x1F90 -> udp_port_error one cycle after header byte 7, no valid; repeated with PORT_FILTER_EN=0 -> normal payload delivery.
4. Length errors: length field 0x0006 -> udp_length_error, udp_rec_data_length=0; length 0x0020 with ip_len=0x0018 -> udp_length_error; length 0x0008 -> udp_rx_end only, zero valid cycles.
5. Abort: ip_checksum_error pulse at payload byte 3 of a 20-byte payload -> valid stops after byte 2, udp_rx_abort once, no udp_rx_end; abort on the final byte's cycle -> final byte valid, abort instead of end.
6. Robustness: second udp_rx_req mid-datagram ignored; rst asserted mid-payload -> all outputs 0 next cycle; back-to-back datagrams with a 1-cycle gap -> both delivered correctly.
